// File: rtl/pld_config_loader_pkg.sv
// Shared definitions for the PLD configuration loader: default image geometry,
// commit FSM encodings, image region map and byte/bit helpers.
package pld_config_loader_pkg;

    localparam int CFG_BYTES_DEF = 64;
    localparam int ADDR_W_DEF    = 6;

    // Commit sequence states; kept as plain constants so older tools and
    // netlists see a fixed binary encoding.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_QUIESCE = 2'd1;
    localparam logic [1:0] ST_SWAP    = 2'd2;
    localparam logic [1:0] ST_RESUME  = 2'd3;

    // Image layout: input terms, output terms, macrocell control.
    localparam int IT_FIRST = 'h00;
    localparam int IT_LAST  = 'h2F;
    localparam int OT_FIRST = 'h30;
    localparam int OT_LAST  = 'h37;
    localparam int MC_FIRST = 'h38;
    localparam int MC_LAST  = 'h3F;

    typedef enum logic [1:0] {
        REGION_IT,
        REGION_OT,
        REGION_MC,
        REGION_NONE
    } cfg_region_e;

    // Bit offset of byte k within the flat config vector.
    function automatic int byte2bit(input int byteIdx);
        return byteIdx * 8;
    endfunction

    // Which functional region of the image a byte address belongs to.
    function automatic cfg_region_e region_of(input int byteIdx);
        if (byteIdx >= IT_FIRST && byteIdx <= IT_LAST) begin
            return REGION_IT;
        end else if (byteIdx >= OT_FIRST && byteIdx <= OT_LAST) begin
            return REGION_OT;
        end else if (byteIdx >= MC_FIRST && byteIdx <= MC_LAST) begin
            return REGION_MC;
        end
        return REGION_NONE;
    endfunction

endpackage

// File: rtl/pld_config_loader_shadow.sv
// Shadow copy of the configuration image plus a per-byte "written since last
// swap" mask. Byte writes land here; the top copies the image out on a swap
// and pulses clear to restart the mask.
module pld_config_loader_shadow
    import pld_config_loader_pkg::*;
#(
    parameter int CFG_BYTES = CFG_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
)
(
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_wr_en,
    input  logic [ADDR_W-1:0]      i_wr_addr,
    input  logic [7:0]             i_wr_data,
    input  logic                   i_clear,
    output logic [CFG_BYTES*8-1:0] o_image,
    output logic [CFG_BYTES-1:0]   o_mask
);

    logic [CFG_BYTES*8-1:0] r_image;
    logic [CFG_BYTES-1:0]   r_mask;
    logic                   w_addr_ok;
    logic                   w_store;

    // Addresses beyond the image only exist when the image is not a power of
    // two; such writes are handshaken by the top but never stored.
    generate
        if (CFG_BYTES == (1 << ADDR_W)) begin : g_addr_full
            assign w_addr_ok = 1'b1;
        end else begin : g_addr_ranged
            assign w_addr_ok = ({1'b0, i_wr_addr} < (ADDR_W+1)'(CFG_BYTES));
        end
    endgenerate

    assign w_store = i_wr_en & w_addr_ok;

    // Store the written byte into its slot of the shadow image.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_image <= '0;
        end else if (w_store) begin
            r_image[byte2bit(int'(i_wr_addr)) +: 8] <= i_wr_data;
        end
    end

    // Track which bytes were written since the last swap; a write in the same
    // cycle as a clear still marks its byte.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_mask <= '0;
        end else begin
            if (i_clear) begin
                r_mask <= '0;
            end
            if (w_store) begin
                r_mask[i_wr_addr] <= 1'b1;
            end
        end
    end

    assign o_image = r_image;
    assign o_mask  = r_mask;

endmodule

// File: rtl/pld_config_loader.sv
// Writer side of the PLD configuration image. Bytes are collected in a shadow
// image; a commit pulse runs a short sequence that drops pld_en, copies the
// whole shadow into the live config in one edge, then re-enables the PLDs.
module pld_config_loader
    import pld_config_loader_pkg::*;
#(
    parameter int CFG_BYTES = CFG_BYTES_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
)
(
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_wr_valid,
    output logic                   o_wr_ready,
    input  logic [ADDR_W-1:0]      i_wr_addr,
    input  logic [7:0]             i_wr_data,
    input  logic                   i_commit,
    input  logic                   i_run,
    output logic [CFG_BYTES*8-1:0] o_config,
    output logic                   o_pld_en,
    output logic                   o_commit_done,
    output logic                   o_partial,
    input  logic [ADDR_W-1:0]      i_rd_addr,
    output logic [7:0]             o_rd_data
);

    logic [1:0]             r_state;
    logic [1:0]             w_next_state;
    logic                   r_wr_ready;
    logic                   r_live_valid;
    logic                   r_pld_en;
    logic                   r_commit_done;
    logic                   r_partial;
    logic [CFG_BYTES*8-1:0] r_config;
    logic [7:0]             r_rd_data;
    logic [CFG_BYTES*8-1:0] w_shadow_image;
    logic [CFG_BYTES-1:0]   w_shadow_mask;
    logic                   w_wr_accept;
    logic                   w_swap;
    logic                   w_rd_ok;

    assign w_wr_accept = i_wr_valid & r_wr_ready;
    assign w_swap      = (r_state == ST_SWAP);

    // Readback of addresses past the image returns zero.
    generate
        if (CFG_BYTES == (1 << ADDR_W)) begin : g_rd_full
            assign w_rd_ok = 1'b1;
        end else begin : g_rd_ranged
            assign w_rd_ok = ({1'b0, i_rd_addr} < (ADDR_W+1)'(CFG_BYTES));
        end
    endgenerate

    pld_config_loader_shadow #(
        .CFG_BYTES (CFG_BYTES),
        .ADDR_W    (ADDR_W)
    ) u_shadow (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (i_wr_addr),
        .i_wr_data (i_wr_data),
        .i_clear   (w_swap),
        .o_image   (w_shadow_image),
        .o_mask    (w_shadow_mask)
    );

    // Commit sequence: a commit is only taken in IDLE, the rest step once per cycle.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:    if (i_commit) w_next_state = ST_QUIESCE;
            ST_QUIESCE: w_next_state = ST_SWAP;
            ST_SWAP:    w_next_state = ST_RESUME;
            ST_RESUME:  w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // State register; ready is registered from the next state so it is low
    // for the first cycle after reset and for the three non-IDLE cycles.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state    <= ST_IDLE;
            r_wr_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_wr_ready <= (w_next_state == ST_IDLE);
        end
    end

    // Live image: the whole shadow is copied in the SWAP cycle, and the
    // partial flag records whether any byte went unwritten since the last swap.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_config     <= '0;
            r_live_valid <= 1'b0;
            r_partial    <= 1'b0;
        end else if (w_swap) begin
            r_config     <= w_shadow_image;
            r_live_valid <= 1'b1;
            r_partial    <= ~&w_shadow_mask;
        end
    end

    // PLD enable follows the next state so it drops on the commit edge and
    // returns on the edge that re-enters IDLE; done pulses during RESUME.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_pld_en      <= 1'b0;
            r_commit_done <= 1'b0;
        end else begin
            r_pld_en      <= i_run & r_live_valid & (w_next_state == ST_IDLE);
            r_commit_done <= w_swap;
        end
    end

    // One-cycle-latency readback of the live image.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= w_rd_ok ? r_config[byte2bit(int'(i_rd_addr)) +: 8] : 8'h00;
        end
    end

    assign o_wr_ready    = r_wr_ready;
    assign o_config      = r_config;
    assign o_pld_en      = r_pld_en;
    assign o_commit_done = r_commit_done;
    assign o_partial     = r_partial;
    assign o_rd_data     = r_rd_data;

endmodule
